// File: rtl/boot_pkg.sv
// Shared definitions for the instruction boot loader: stream framing constants and FSM states.
package boot_pkg;

  localparam int INSTR_W    = 19;
  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 3;

  // Bits of the third word byte that carry no instruction data and must be zero.
  localparam logic [7:0] RSVD_MASK = 8'hF8;

  typedef enum logic [2:0] {
    ST_HDR0,
    ST_HDR1,
    ST_B0,
    ST_B1,
    ST_B2,
    ST_WRITE,
    ST_RUN,
    ST_ERR
  } boot_state_e;

endpackage

// File: rtl/boot_word_assembler.sv
// Collects the three little-endian bytes of one instruction word. The first two bytes
// are held in a shift register; the third is taken live so the full word and its
// format check are available in the same cycle the last byte arrives.
module boot_word_assembler
  import boot_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               shift_en,
  input  logic [7:0]         byte_in,
  output logic [INSTR_W-1:0] word,
  output logic               fmt_err
);

  localparam int LOW_W = (WORD_BYTES - 1) * 8;
  localparam int TOP_W = INSTR_W - LOW_W;

  logic [LOW_W-1:0] low_bytes;

  // Shift byte 0 then byte 1 in from the top so byte 0 ends up least significant.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      low_bytes <= '0;
    end else if (shift_en) begin
      low_bytes <= {byte_in, low_bytes[LOW_W-1:8]};
    end
  end

  // Byte 2 contributes the top instruction bits; anything in its upper bits is malformed.
  always_comb begin
    word    = {byte_in[TOP_W-1:0], low_bytes};
    fmt_err = |(byte_in & RSVD_MASK);
  end

endmodule

// File: rtl/instr_boot_loader.sv
// Boot loader: parses a word-count header and 3-byte instruction words from a byte
// stream, writes them to instruction memory and releases the core once all words land.
module instr_boot_loader #(
  parameter int ADDR_W  = 12,
  parameter int INSTR_W = boot_pkg::INSTR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_reset,
  output logic               load_done,
  output logic               load_error
);

  import boot_pkg::*;

  localparam int          CNT_W = ADDR_W + 1;
  localparam int          HDR_W = HDR_BYTES * 8;
  localparam logic [31:0] DEPTH = 32'(1) << ADDR_W;

  boot_state_e        state, state_nxt;
  logic [7:0]         hdr_lo;
  logic [HDR_W-1:0]   word_cnt;
  logic [HDR_W-1:0]   hdr_n;
  logic [CNT_W-1:0]   word_idx;
  logic               xfer;
  logic               last_word;
  logic [INSTR_W-1:0] asm_word;
  logic               asm_fmt_err;

  assign xfer      = rx_valid && rx_ready;
  assign hdr_n     = {rx_data, hdr_lo};
  // The counter is one bit wider than the address so N = depth never aliases to 0.
  assign last_word = (32'(word_idx) + 32'd1) == 32'(word_cnt);

  boot_word_assembler u_asm (
    .clk      (clk),
    .reset    (reset),
    .clear    (state == ST_HDR1),
    .shift_en (xfer && ((state == ST_B0) || (state == ST_B1))),
    .byte_in  (rx_data),
    .word     (asm_word),
    .fmt_err  (asm_fmt_err)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_HDR0;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and byte-accept handshake.
  always_comb begin
    state_nxt = state;
    rx_ready  = 1'b0;
    case (state)
      ST_HDR0: begin
        rx_ready = 1'b1;
        if (rx_valid) state_nxt = ST_HDR1;
      end
      ST_HDR1: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          if (32'(hdr_n) > DEPTH)   state_nxt = ST_ERR;
          else if (hdr_n == '0)     state_nxt = ST_RUN;
          else                      state_nxt = ST_B0;
        end
      end
      ST_B0: begin
        rx_ready = 1'b1;
        if (rx_valid) state_nxt = ST_B1;
      end
      ST_B1: begin
        rx_ready = 1'b1;
        if (rx_valid) state_nxt = ST_B2;
      end
      ST_B2: begin
        rx_ready = 1'b1;
        if (rx_valid) state_nxt = asm_fmt_err ? ST_ERR : ST_WRITE;
      end
      ST_WRITE: state_nxt = last_word ? ST_RUN : ST_B0;
      ST_RUN:   state_nxt = ST_RUN;
      ST_ERR:   state_nxt = ST_ERR;
      default:  state_nxt = ST_HDR0;
    endcase
    if (reset) rx_ready = 1'b0;
  end

  // Header capture; only meaningful after an accepted header byte, so left unreset.
  always_ff @(posedge clk) begin
    if (xfer && (state == ST_HDR0)) hdr_lo   <= rx_data;
    if (xfer && (state == ST_HDR1)) word_cnt <= hdr_n;
  end

  // Word index and registered outputs, all derived from the upcoming state.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_idx   <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_reset  <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      if (state == ST_HDR1)       word_idx <= '0;
      else if (state == ST_WRITE) word_idx <= word_idx + 1'b1;
      imem_we <= (state_nxt == ST_WRITE);
      if (state_nxt == ST_WRITE) begin
        imem_addr  <= word_idx[ADDR_W-1:0];
        imem_wdata <= asm_word;
      end
      cpu_reset  <= (state_nxt != ST_RUN);
      load_done  <= (state_nxt == ST_RUN);
      load_error <= (state_nxt == ST_ERR);
    end
  end

endmodule

// File: tb/tb_instr_boot_loader.sv
// Bench for instr_boot_loader: directed and randomized byte streams checked against a
// stream-level reference model, on a default-size instance and a 4-word instance.
module tb_instr_boot_loader;

  typedef struct {
    int inst;
    int addr;
    int data;
    int cyc;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [7:0]  rxd [2];
  logic        rxv [2];

  logic        rdy_a, we_a, cpur_a, done_a, err_a;
  logic [11:0] addr_a;
  logic [18:0] wd_a;
  logic        rdy_b, we_b, cpur_b, done_b, err_b;
  logic [1:0]  addr_b;
  logic [18:0] wd_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  instr_boot_loader #(.ADDR_W(12)) u_dut_a (
    .clk(clk), .reset(reset), .rx_data(rxd[0]), .rx_valid(rxv[0]), .rx_ready(rdy_a),
    .imem_we(we_a), .imem_addr(addr_a), .imem_wdata(wd_a),
    .cpu_reset(cpur_a), .load_done(done_a), .load_error(err_a)
  );

  instr_boot_loader #(.ADDR_W(2)) u_dut_b (
    .clk(clk), .reset(reset), .rx_data(rxd[1]), .rx_valid(rxv[1]), .rx_ready(rdy_b),
    .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wd_b),
    .cpu_reset(cpur_b), .load_done(done_b), .load_error(err_b)
  );

  function automatic logic [31:0] o_rdy(input int k);  return k == 0 ? 32'(rdy_a)  : 32'(rdy_b);  endfunction
  function automatic logic [31:0] o_we(input int k);   return k == 0 ? 32'(we_a)   : 32'(we_b);   endfunction
  function automatic logic [31:0] o_addr(input int k); return k == 0 ? 32'(addr_a) : 32'(addr_b); endfunction
  function automatic logic [31:0] o_wd(input int k);   return k == 0 ? 32'(wd_a)   : 32'(wd_b);   endfunction
  function automatic logic [31:0] o_cpur(input int k); return k == 0 ? 32'(cpur_a) : 32'(cpur_b); endfunction
  function automatic logic [31:0] o_done(input int k); return k == 0 ? 32'(done_a) : 32'(done_b); endfunction
  function automatic logic [31:0] o_err(input int k);  return k == 0 ? 32'(err_a)  : 32'(err_b);  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Observed write log, back-to-back strobe count and rise cycles of done/error.
  wr_t  wq [$];
  int   dbl [2]       = '{0, 0};
  int   done_rise [2] = '{-1, -1};
  int   err_rise [2]  = '{-1, -1};
  logic pw [2]        = '{1'b0, 1'b0};
  logic pd [2]        = '{1'b0, 1'b0};
  logic pe [2]        = '{1'b0, 1'b0};

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (o_we(k) != 0) begin
        wq.push_back('{inst: k, addr: int'(o_addr(k)), data: int'(o_wd(k)), cyc: cyc});
        if (pw[k]) dbl[k] <= dbl[k] + 1;
      end
      if ((o_done(k) != 0) && !pd[k]) done_rise[k] <= cyc;
      if ((o_err(k) != 0) && !pe[k])  err_rise[k]  <= cyc;
      pw[k] <= (o_we(k) != 0);
      pd[k] <= (o_done(k) != 0);
      pe[k] <= (o_err(k) != 0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: interprets the stream by its framing rules.
  // st: 0 = core released, 1 = format error.
  task automatic model(input logic [7:0] b[$], input int depth,
                       output int acc, output int st, output wr_t ew[$]);
    int n;
    ew  = {};
    n   = int'(b[0]) + 256 * int'(b[1]);
    acc = 2;
    st  = 0;
    if (n > depth) begin
      st = 1;
      return;
    end
    for (int w = 0; w < n; w++) begin
      int p;
      p = 2 + 3 * w;
      acc += 3;
      if ((b[p+2] & 8'hF8) != 0) begin
        st = 1;
        return;
      end
      ew.push_back('{inst: 0, addr: w,
                     data: int'(b[p]) + 256 * int'(b[p+1]) + 65536 * int'(b[p+2] & 8'h07),
                     cyc: p + 2});
    end
  endtask

  // Offer bytes with random idle gaps; give up on a byte the loader refuses for 8 cycles.
  task automatic send(input int k, input logic [7:0] b[$], input int maxgap,
                      output int acc, output int xc[$]);
    int w;
    acc = 0;
    xc  = {};
    for (int i = 0; i < b.size(); i++) begin
      rxv[k] = 1'b0;
      repeat ((maxgap > 0) ? $urandom_range(0, maxgap) : 0) @(negedge clk);
      rxd[k] = b[i];
      rxv[k] = 1'b1;
      #1;
      w = 0;
      while ((o_rdy(k) == 0) && (w < 8)) begin
        @(negedge clk);
        #1;
        w++;
      end
      if (o_rdy(k) == 0) begin
        rxv[k] = 1'b0;
        break;
      end
      @(negedge clk);
      acc++;
      xc.push_back(cyc);
    end
    rxv[k] = 1'b0;
  endtask

  task automatic do_reset(input bit check);
    @(negedge clk);
    reset  = 1'b1;
    rxv[0] = 1'b0;
    rxv[1] = 1'b0;
    @(negedge clk);
    #1;
    if (check) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("rst%0d rx_ready", k),   o_rdy(k),  0);
        chk($sformatf("rst%0d imem_we", k),    o_we(k),   0);
        chk($sformatf("rst%0d imem_addr", k),  o_addr(k), 0);
        chk($sformatf("rst%0d imem_wdata", k), o_wd(k),   0);
        chk($sformatf("rst%0d cpu_reset", k),  o_cpur(k), 1);
        chk($sformatf("rst%0d load_done", k),  o_done(k), 0);
        chk($sformatf("rst%0d load_error", k), o_err(k),  0);
      end
    end
    reset = 1'b0;
    #1;
    if (check) chk("rst ready after release", o_rdy(0), 1);
    @(negedge clk);
  endtask

  task automatic run_stream(input int k, input string tag, input logic [7:0] b[$], input int maxgap);
    int   acc, eacc, st, base, db0, e;
    int   xc [$];
    wr_t  ew [$];
    wr_t  got [$];
    model(b, (k == 0) ? 4096 : 4, eacc, st, ew);
    base = wq.size();
    db0  = dbl[k];
    send(k, b, maxgap, acc, xc);
    repeat (6) @(negedge clk);
    #1;
    got = {};
    for (int i = base; i < wq.size(); i++) if (wq[i].inst == k) got.push_back(wq[i]);
    chk({tag, " accepted"}, acc, eacc);
    chk({tag, " nwrites"}, got.size(), ew.size());
    for (int i = 0; (i < ew.size()) && (i < got.size()); i++) begin
      chk($sformatf("%s addr%0d", tag, i), got[i].addr, ew[i].addr);
      chk($sformatf("%s data%0d", tag, i), got[i].data, ew[i].data);
      if (ew[i].cyc < xc.size()) chk($sformatf("%s wcyc%0d", tag, i), got[i].cyc, xc[ew[i].cyc]);
    end
    chk({tag, " back-to-back we"}, dbl[k], db0);
    chk({tag, " cpu_reset"},  o_cpur(k), (st == 0) ? 0 : 1);
    chk({tag, " load_done"},  o_done(k), (st == 0) ? 1 : 0);
    chk({tag, " load_error"}, o_err(k),  (st == 1) ? 1 : 0);
    chk({tag, " rx_ready"},   o_rdy(k),  0);
    if ((st == 0) && (xc.size() == eacc)) begin
      e = (ew.size() > 0) ? xc[ew[ew.size()-1].cyc] + 1 : xc[1];
      chk({tag, " release cycle"}, done_rise[k], e);
    end
    if ((st == 1) && (xc.size() == eacc) && (eacc > 0)) begin
      chk({tag, " error cycle"}, err_rise[k], xc[eacc-1]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] s [$];
    logic [7:0] b2;
    int         n, acc, base, cnt;
    int         xc [$];

    reset  = 1'b1;
    rxv[0] = 1'b0;
    rxv[1] = 1'b0;
    rxd[0] = 8'h00;
    rxd[1] = 8'h00;

    do_reset(1);

    s = {8'h02, 8'h00, 8'h34, 8'h12, 8'h05, 8'hFF, 8'hFF, 8'h07};
    run_stream(0, "n2", s, 0);
    for (int r = 0; r < 3; r++) begin
      do_reset(0);
      run_stream(0, $sformatf("n2gap%0d", r), s, 5);
    end

    do_reset(0);
    s = {8'h00, 8'h00};
    run_stream(0, "n0", s, 0);

    do_reset(0);
    s = {8'h01, 8'h00, 8'hAA, 8'hBB, 8'h08};
    run_stream(0, "fmterr", s, 2);

    do_reset(0);
    s = {8'h01, 8'h10, 8'h00, 8'h00, 8'h00};
    run_stream(0, "n4097", s, 0);

    do_reset(0);
    s = {8'h05, 8'h00};
    repeat (5) begin
      s.push_back(8'($urandom));
      s.push_back(8'($urandom));
      s.push_back(8'($urandom_range(0, 7)));
    end
    run_stream(1, "aw2 n5", s, 1);

    do_reset(0);
    s = {8'h04, 8'h00};
    repeat (4) begin
      s.push_back(8'($urandom));
      s.push_back(8'($urandom));
      s.push_back(8'($urandom_range(0, 7)));
    end
    run_stream(1, "aw2 n4", s, 3);

    for (int r = 0; r < 5; r++) begin
      do_reset(0);
      n = $urandom_range(1, 5);
      s = {8'(n), 8'h00};
      for (int w = 0; w < n; w++) begin
        s.push_back(8'($urandom));
        s.push_back(8'($urandom));
        b2 = 8'($urandom_range(0, 7));
        if ($urandom_range(0, 7) == 0) b2 = b2 | 8'(($urandom_range(1, 31)) << 3);
        s.push_back(b2);
      end
      run_stream(0, $sformatf("rand%0d", r), s, 5);
    end

    // Reset in the middle of an N=3 load, then a fresh single-word stream.
    do_reset(0);
    base = wq.size();
    s = {8'h03, 8'h00, 8'h11, 8'h22, 8'h03};
    send(0, s, 2, acc, xc);
    repeat (3) @(negedge clk);
    cnt = 0;
    for (int i = base; i < wq.size(); i++) if (wq[i].inst == 0) cnt++;
    chk("midload first word written", cnt, 1);
    chk("midload core held", o_cpur(0), 1);
    do_reset(1);
    s = {8'h01, 8'h00, 8'h01, 8'h00, 8'h00};
    run_stream(0, "after reset", s, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
